// File: rtl/bin_vers_bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin_vers_bcd
// Description : Sequential binary-to-BCD converter (shift-add-3, one input bit
//               per clock) feeding the 3-digit dice-result display. Produces
//               hundreds/tens/units digits, leading-zero blanking enables and
//               an overflow flag that saturates the display to 999.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous reset, active low
//               start        conversion request, sampled while pret=1
//               valeur       unsigned binary value (LARG bits)
//               pret         1 = idle, start will be accepted
//               fini         one-cycle pulse, new result on outputs
//               bcd100/10/1  BCD digits of the last result
//               en100/en10   display enables for hundreds/tens digits
//               depassement  last converted value exceeded 999
// Revision    : 1.0 - initial release
// ============================================================================
module bin_vers_bcd #(
    parameter int LARG = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [LARG-1:0] valeur,
    output logic            pret,
    output logic            fini,
    output logic [3:0]      bcd100,
    output logic [3:0]      bcd10,
    output logic [3:0]      bcd1,
    output logic            en100,
    output logic            en10,
    output logic            depassement
);

    localparam int c_CW = $clog2(LARG + 1);

    localparam logic [1:0] c_REPOS  = 2'd0;
    localparam logic [1:0] c_DECALE = 2'd1;
    localparam logic [1:0] c_FIN    = 2'd2;

    logic [1:0]      r_state;
    logic [LARG-1:0] r_shift;
    logic [11:0]     r_acc;
    logic            r_ovf;
    logic [c_CW-1:0] r_cnt;

    logic [11:0]     w_adj;
    logic [11:0]     w_acc_next;
    logic [3:0]      w_d100;
    logic [3:0]      w_d10;
    logic [3:0]      w_d1;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

    // Correct each digit before the shift so it carries properly into the
    // next digit after doubling.
    always_comb begin
        w_adj      = {add3(r_acc[11:8]), add3(r_acc[7:4]), add3(r_acc[3:0])};
        w_acc_next = {w_adj[10:0], r_shift[LARG-1]};
    end

    // Saturated digits: a bit ever shifted out of the hundreds digit means the
    // value needed a thousands digit, so display 999 instead.
    always_comb begin
        if (r_ovf) begin
            w_d100 = 4'd9;
            w_d10  = 4'd9;
            w_d1   = 4'd9;
        end else begin
            w_d100 = r_acc[11:8];
            w_d10  = r_acc[7:4];
            w_d1   = r_acc[3:0];
        end
    end

    assign pret = (r_state == c_REPOS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_REPOS;
            r_shift     <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            fini        <= 1'b0;
            bcd100      <= 4'd0;
            bcd10       <= 4'd0;
            bcd1        <= 4'd0;
            en100       <= 1'b0;
            en10        <= 1'b0;
            depassement <= 1'b0;
        end else begin
            fini <= 1'b0;
            case (r_state)
                c_REPOS: begin
                    if (start) begin
                        r_shift <= valeur;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= c_CW'(LARG);
                        r_state <= c_DECALE;
                    end
                end
                c_DECALE: begin
                    r_acc   <= w_acc_next;
                    r_shift <= {r_shift[LARG-2:0], 1'b0};
                    r_ovf   <= r_ovf | w_adj[11];
                    r_cnt   <= r_cnt - c_CW'(1);
                    if (r_cnt == c_CW'(1)) begin
                        r_state <= c_FIN;
                    end
                end
                c_FIN: begin
                    bcd100      <= w_d100;
                    bcd10       <= w_d10;
                    bcd1        <= w_d1;
                    en100       <= (w_d100 != 4'd0);
                    en10        <= (w_d100 != 4'd0) || (w_d10 != 4'd0);
                    depassement <= r_ovf;
                    fini        <= 1'b1;
                    r_state     <= c_REPOS;
                end
                default: begin
                    r_state <= c_REPOS;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin_vers_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_vers_bcd
// Description : Scoreboard bench for bin_vers_bcd. Stimulus pushes the
//               hand-computed result and its due cycle; a monitor pops and
//               compares on every fini pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_vers_bcd;

    localparam int LARG = 10;

    typedef struct {
        int h;
        int t;
        int u;
        int dep;
        int due;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [LARG-1:0] valeur;
    logic            pret;
    logic            fini;
    logic [3:0]      bcd100;
    logic [3:0]      bcd10;
    logic [3:0]      bcd1;
    logic            en100;
    logic            en10;
    logic            depassement;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    bin_vers_bcd #(.LARG(LARG)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .valeur      (valeur),
        .pret        (pret),
        .fini        (fini),
        .bcd100      (bcd100),
        .bcd10       (bcd10),
        .bcd1        (bcd1),
        .en100       (en100),
        .en10        (en10),
        .depassement (depassement)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_assert = n_assert + 1;
        if (act != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every fini pulse must match the oldest pending expectation,
    // arrive exactly on its due cycle, and nothing may stay overdue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fini) begin
                if (sb.size() == 0) begin
                    chk("unexpected_fini", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cyc, e.due);
                    chk("digits", {bcd100, bcd10, bcd1}, (e.h << 8) | (e.t << 4) | e.u);
                    chk("en100", en100, (e.h != 0) ? 1 : 0);
                    chk("en10", en10, (e.h != 0 || e.t != 0) ? 1 : 0);
                    chk("depassement", depassement, e.dep);
                end
            end else if (sb.size() != 0 && cyc > sb[0].due) begin
                chk("fini_timeout", 0, 1);
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge; the next posedge accepts the request and fini is
    // due LARG+1 edges after that.
    task automatic issue(input int v, input int h, input int t, input int u, input int dep);
        exp_t e;
        int guard = 0;
        while (!pret && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("pret_before_start", pret, 1);
        valeur = LARG'(v);
        start  = 1'b1;
        e.h = h; e.t = t; e.u = u; e.dep = dep;
        e.due = cyc + 1 + LARG + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic convert(input int v, input int h, input int t, input int u, input int dep);
        issue(v, h, t, u, dep);
        repeat (LARG + 2) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        valeur = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_pret", pret, 1);
        chk("rst_fini", fini, 0);
        chk("rst_digits", {bcd100, bcd10, bcd1}, 0);
        chk("rst_en", {en100, en10}, 0);
        chk("rst_dep", depassement, 0);

        // Basic values and boundaries
        convert(7,    0, 0, 7, 0);
        convert(42,   0, 4, 2, 0);
        convert(100,  1, 0, 0, 0);
        convert(0,    0, 0, 0, 0);
        convert(999,  9, 9, 9, 0);
        convert(1023, 9, 9, 9, 1);
        convert(1000, 9, 9, 9, 1);
        convert(5,    0, 0, 5, 0);
        convert(509,  5, 0, 9, 0);

        // Requests during conversion are ignored; outputs hold previous result
        issue(250, 2, 5, 0, 0);
        for (int i = 2; i <= 8; i++) begin
            if (i == 3 || i == 6) begin
                valeur = LARG'(3);
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            chk("hold_digits", {bcd100, bcd10, bcd1}, 'h509);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (LARG) @(negedge clk);

        // Start held high: back-to-back conversions every LARG+2 cycles
        begin
            exp_t e;
            valeur = LARG'(123);
            start  = 1'b1;
            e.h = 1; e.t = 2; e.u = 3; e.dep = 0;
            e.due = cyc + 1 + LARG + 1;
            sb.push_back(e);
            e.due = e.due + LARG + 2;
            sb.push_back(e);
            repeat (LARG + 3) @(negedge clk);
            start = 1'b0;
            repeat (LARG + 2) @(negedge clk);
        end

        // Mid-conversion reset abandons the conversion
        issue(640, 6, 4, 0, 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_pret", pret, 1);
        chk("midrst_digits", {bcd100, bcd10, bcd1}, 0);
        chk("midrst_en_dep", {en100, en10, depassement}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (LARG + 4) @(negedge clk);
        chk("midrst_digits_held", {bcd100, bcd10, bcd1}, 0);
        convert(640, 6, 4, 0, 0);
        convert(91,  0, 9, 1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
